// File: rtl/gray_ptr_pkg.sv
// Shared helpers for the gray-coded pointer link: gray/binary conversion and
// synchroniser limits. The conversion functions work on a fixed maximum width.
// Callers zero-extend narrower pointers and truncate the result. This is
// exact for any pointer width up to PTR_W_MAX.
package gray_ptr_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int PTR_W_MAX       = 32;

    typedef logic [PTR_W_MAX-1:0] ptr_max_t;

    // Binary to reflected gray code.
    function automatic ptr_max_t bin2gray(input ptr_max_t b);
        return (b >> 1) ^ b;
    endfunction

    // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
    function automatic ptr_max_t gray2bin(input ptr_max_t g);
        ptr_max_t b;
        b = '0;
        for (int i = 0; i < PTR_W_MAX; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_sync_chain.sv
// Multi-flop synchroniser for a gray-coded bus crossing into the clk domain.
// The bus is gray-coded, so at most one bit is in flight per source step.
// That makes per-bit synchronisation safe. Stage counts below SYNC_STAGES_MIN
// are raised to the minimum.
module gray_sync_chain
    import gray_ptr_pkg::*;
#(
    parameter int SIZE        = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SIZE-1:0] d,
    output logic [SIZE-1:0] q
);

    localparam int STAGES = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

    (* ASYNC_REG = "TRUE" *) logic [SIZE-1:0] sync_q [STAGES];

    // Shift the asynchronous bus through the synchroniser flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the chain is reset so the first decoded pointer after reset is a
            // known zero. The chain is a short flop array, not a RAM, so resetting it is cheap.
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make every stage sample its
            // predecessor's old value, giving a true shift register.
            sync_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/gray_ptr_rx.sv
// Read side of a gray-coded pointer link for an asynchronous FIFO.
// The remote write pointer is synchronised, decoded and registered.
// The module keeps the local binary/gray read pointer and derives occupancy and empty.
// Optional feature macro: GRAY_PTR_CHECK_EN. When defined, a multi-bit change of
// the synchronised gray pointer between consecutive cycles sets sticky gray_err.
// When not defined, gray_err is tied low.
module gray_ptr_rx
    import gray_ptr_pkg::*;
#(
    parameter int SIZE        = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SIZE-1:0] gray_in,
    input  logic            inc,
    output logic [SIZE-1:0] rd_bin,
    output logic [SIZE-1:0] rd_gray,
    output logic [SIZE-1:0] wr_bin,
    output logic [SIZE-1:0] count,
    output logic            empty,
    output logic            underflow,
    output logic            gray_err
);

    logic [SIZE-1:0] g_s;
    logic [SIZE-1:0] wr_bin_next;
    logic [SIZE-1:0] rd_bin_inc;
    logic            pop_ok;

    gray_sync_chain #(
        .SIZE        (SIZE),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (gray_in),
        .q     (g_s)
    );

    assign wr_bin_next = SIZE'(gray2bin(ptr_max_t'(g_s)));
    assign rd_bin_inc  = rd_bin + SIZE'(1);

    // Occupancy is straight from the pointer registers; modulo wrap handles the wrap bit.
    assign count  = wr_bin - rd_bin;
    assign empty  = (count == '0);
    assign pop_ok = inc && !empty;

    // Register the decoded write pointer one cycle behind the synchroniser output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_bin <= '0;
        end else begin
            wr_bin <= wr_bin_next;
        end
    end

    // Advance binary and gray read pointers together on an accepted pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_bin  <= '0;
            rd_gray <= '0;
        end else if (pop_ok) begin
            rd_bin  <= rd_bin_inc;
            rd_gray <= SIZE'(bin2gray(ptr_max_t'(rd_bin_inc)));
        end
    end

    // Flag a pop request made while empty; the flag is held until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            underflow <= 1'b0;
        end else if (inc && empty) begin
            underflow <= 1'b1;
        end
    end

`ifdef GRAY_PTR_CHECK_EN
    logic [SIZE-1:0] g_s_prev;
    logic [SIZE-1:0] g_s_diff;

    // A legal gray sequence changes one bit per step.
    // diff & (diff-1) is non-zero exactly when two or more bits differ.
    assign g_s_diff = g_s ^ g_s_prev;

    // Track the previous synchronised pointer and latch any multi-bit step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            g_s_prev <= '0;
            gray_err <= 1'b0;
        end else begin
            g_s_prev <= g_s;
            if (|(g_s_diff & (g_s_diff - SIZE'(1)))) begin
                gray_err <= 1'b1;
            end
        end
    end
`else
    assign gray_err = 1'b0;
`endif

endmodule
